// File: rtl/instruction_fetch_stage.sv
// RV32I fetch stage: owns the PC, issues one word fetch at a time over req/gnt/rvalid,
// and holds the IF/ID register (with a one-entry skid buffer) for decode.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        Redirect_i,
    input  logic [31:0] Redirect_pc_i,
    output logic        Imem_req_o,
    output logic [31:0] Imem_addr_o,
    input  logic        Imem_gnt_i,
    input  logic        Imem_rvalid_i,
    input  logic [31:0] Imem_rdata_i,
    output logic        Instr_valid_o,
    output logic [31:0] Instr_o,
    output logic [31:0] Pc_o,
    output logic [31:0] Pc_plus4_o
);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] fetch_pc_q;
    logic        drop_q;
    entry_t      ifid_q;
    entry_t      skid_q;

    logic        grant;
    logic        resp;

    // Request is withheld while the skid holds a word, so the skid can never overflow.
    assign Imem_req_o  = (state_q == S_REQ) && !skid_q.vld && !rst_i;
    assign Imem_addr_o = pc_q;
    assign grant       = Imem_req_o && Imem_gnt_i;
    assign resp        = (state_q == S_WAIT) && Imem_rvalid_i;

    assign Instr_valid_o = ifid_q.vld;
    assign Instr_o       = ifid_q.instr;
    assign Pc_o          = ifid_q.pc;
    assign Pc_plus4_o    = ifid_q.pc + 32'd4;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            drop_q       <= 1'b0;
            ifid_q.vld   <= 1'b0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.pc    <= RESET_PC;
            skid_q.vld   <= 1'b0;
            skid_q.instr <= NOP_INSTR;
            skid_q.pc    <= RESET_PC;
        end else if (Redirect_i) begin
            pc_q         <= {Redirect_pc_i[31:2], 2'b00};
            ifid_q.vld   <= 1'b0;
            ifid_q.instr <= NOP_INSTR;
            skid_q.vld   <= 1'b0;
            if (resp) begin
                state_q <= S_REQ;
                drop_q  <= 1'b0;
            end else if ((state_q == S_WAIT) || grant) begin
                // A fetch is still in flight: swallow its response when it lands.
                state_q <= S_WAIT;
                drop_q  <= 1'b1;
            end
        end else begin
            if (grant) begin
                fetch_pc_q <= pc_q;
                pc_q       <= pc_q + 32'd4;
                state_q    <= S_WAIT;
            end
            if (resp) begin
                state_q <= S_REQ;
                drop_q  <= 1'b0;
            end
            if (resp && !drop_q) begin
                if (!Stall_i || !ifid_q.vld) begin
                    ifid_q.vld   <= 1'b1;
                    ifid_q.instr <= Imem_rdata_i;
                    ifid_q.pc    <= fetch_pc_q;
                end else begin
                    skid_q.vld   <= 1'b1;
                    skid_q.instr <= Imem_rdata_i;
                    skid_q.pc    <= fetch_pc_q;
                end
            end else if (!Stall_i) begin
                if (skid_q.vld) begin
                    ifid_q     <= skid_q;
                    skid_q.vld <= 1'b0;
                end else begin
                    ifid_q.vld   <= 1'b0;
                    ifid_q.instr <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a small req/gnt/rvalid memory model
// whose grant and response delays are set per step.
module tb_instruction_fetch_stage;

    logic        clk, rst, stall, redir;
    logic [31:0] rpc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        ivalid;
    logic [31:0] instr, pc, pc4;

    int checks = 0;
    int errors = 0;

    int gnt_dly = 0;
    int rv_dly  = 0;
    int gwait, rcnt;
    logic        pend;
    logic [31:0] paddr;

    instruction_fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .Stall_i(stall), .Redirect_i(redir), .Redirect_pc_i(rpc),
        .Imem_req_o(imem_req), .Imem_addr_o(imem_addr), .Imem_gnt_i(imem_gnt),
        .Imem_rvalid_i(imem_rvalid), .Imem_rdata_i(imem_rdata),
        .Instr_valid_o(ivalid), .Instr_o(instr), .Pc_o(pc), .Pc_plus4_o(pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        else if (a == 32'h4) return 32'h00A0_0113;
        else return {a[23:0], 8'h13};
    endfunction

    assign imem_gnt    = imem_req && (gwait >= gnt_dly);
    assign imem_rvalid = pend && (rcnt >= rv_dly);
    assign imem_rdata  = pend ? word(paddr) : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gwait <= 0;
            rcnt  <= 0;
            pend  <= 1'b0;
            paddr <= 32'h0;
        end else begin
            if (imem_req && !imem_gnt) gwait <= gwait + 1;
            else gwait <= 0;
            if (imem_gnt) begin
                pend  <= 1'b1;
                paddr <= imem_addr;
                rcnt  <= 0;
            end else if (imem_rvalid) begin
                pend <= 1'b0;
            end else if (pend) begin
                rcnt <= rcnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ivalid && n < 20);
        check(name, {31'h0, ivalid}, 32'h1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   {31'h0, imem_req}, 32'h0);
        check({tag, "_addr"},  imem_addr, 32'h0);
        check({tag, "_valid"}, {31'h0, ivalid}, 32'h0);
        check({tag, "_instr"}, instr, 32'h0000_0013);
        check({tag, "_pc"},    pc, 32'h0);
        check({tag, "_pc4"},   pc4, 32'h4);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        repeat (2) @(negedge clk);
        check_reset("rst");

        // Zero-wait fetch of 0 and 4
        rst = 1'b0;
        #1;
        check("t1_req0",  {31'h0, imem_req}, 32'h1);
        check("t1_addr0", imem_addr, 32'h0);
        step();
        check("t1_wait_req", {31'h0, imem_req}, 32'h0);
        step();
        check("t1_valid0", {31'h0, ivalid}, 32'h1);
        check("t1_instr0", instr, 32'h0050_0093);
        check("t1_pc0",    pc, 32'h0);
        check("t1_addr4",  imem_addr, 32'h4);
        step();
        check("t1_bubble", {31'h0, ivalid}, 32'h0);
        step();
        check("t1_valid1", {31'h0, ivalid}, 32'h1);
        check("t1_instr1", instr, 32'h00A0_0113);
        check("t1_pc1",    pc, 32'h4);
        check("t1_pc4_1",  pc4, 32'h8);
        check("t1_addr8",  imem_addr, 32'h8);

        // Stall for 4 cycles while the fetch of 8 returns into the skid
        stall = 1'b1;
        repeat (3) begin
            step();
            check("t2_frz_instr", instr, 32'h00A0_0113);
            check("t2_frz_pc",    pc, 32'h4);
            check("t2_frz_valid", {31'h0, ivalid}, 32'h1);
        end
        step();
        check("t2_frz_instr", instr, 32'h00A0_0113);
        check("t2_noreq",     {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        step();
        check("t2_skid_instr", instr, 32'h0000_0813);
        check("t2_skid_pc",    pc, 32'h8);
        check("t2_skid_valid", {31'h0, ivalid}, 32'h1);
        check("t2_req_again",  {31'h0, imem_req}, 32'h1);
        check("t2_addr12",     imem_addr, 32'hC);
        step();
        check("t2_bubble", {31'h0, ivalid}, 32'h0);
        step();
        check("t2_next_instr", instr, 32'h0000_0C13);
        check("t2_next_pc",    pc, 32'hC);

        // Redirect while a slow fetch is outstanding
        rv_dly = 3;
        step();
        check("t3_inwait", {31'h0, imem_req}, 32'h0);
        redir = 1'b1; rpc = 32'h0000_0100;
        step();
        redir = 1'b0;
        check("t3_flush_valid", {31'h0, ivalid}, 32'h0);
        check("t3_flush_instr", instr, 32'h0000_0013);
        repeat (2) begin
            step();
            check("t3_hold_valid", {31'h0, ivalid}, 32'h0);
            check("t3_hold_req",   {31'h0, imem_req}, 32'h0);
        end
        step();
        check("t3_req",   {31'h0, imem_req}, 32'h1);
        check("t3_addr",  imem_addr, 32'h100);
        check("t3_valid", {31'h0, ivalid}, 32'h0);
        rv_dly = 0;
        wait_valid("t3_wait_valid");
        check("t3_pc",    pc, 32'h100);
        check("t3_instr", instr, 32'h0001_0013);

        // Redirect and stall together
        stall = 1'b1; redir = 1'b1; rpc = 32'h0000_0200;
        step();
        check("t4_valid", {31'h0, ivalid}, 32'h0);
        check("t4_instr", instr, 32'h0000_0013);
        stall = 1'b0; redir = 1'b0;
        step();
        check("t4_req",  {31'h0, imem_req}, 32'h1);
        check("t4_addr", imem_addr, 32'h200);
        wait_valid("t4_wait_valid");
        check("t4_pc",    pc, 32'h200);
        check("t4_instr", instr, 32'h0002_0013);

        // Redirect to the top word; PC wraps to zero afterwards
        redir = 1'b1; rpc = 32'hFFFF_FFFF;
        step();
        redir = 1'b0;
        wait_valid("t5_wait_valid");
        check("t5_pc",       pc, 32'hFFFF_FFFC);
        check("t5_instr",    instr, 32'hFFFF_FC13);
        check("t5_pc4_wrap", pc4, 32'h0);
        check("t5_addr_wrap", imem_addr, 32'h0);
        check("t5_req",      {31'h0, imem_req}, 32'h1);

        // Slow grant then reset pulsed while waiting for the response
        stall = 1'b1; gnt_dly = 3; rv_dly = 2;
        repeat (3) begin
            step();
            check("t6_req_held",  {31'h0, imem_req}, 32'h1);
            check("t6_addr_held", imem_addr, 32'h0);
            check("t6_pc_frozen", pc, 32'hFFFF_FFFC);
        end
        step();
        check("t6_inwait", {31'h0, imem_req}, 32'h0);
        rst = 1'b1;
        #1;
        check_reset("t6_async");
        repeat (2) step();
        rst = 1'b0; stall = 1'b0; gnt_dly = 0; rv_dly = 0;
        wait_valid("t6_recover_valid");
        check("t6_recover_pc",    pc, 32'h0);
        check("t6_recover_instr", instr, 32'h0050_0093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
